// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two requesters, the data-memory arbiter and data_mem.
// master: requester/memory side (drives requests and memory read data).
// slave : arbiter side (drives grants, read return and memory strobes).
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU MEM stage (port 0) and debug/loader (port 1)
// share one synchronous single-port data_mem. Grants are combinational (zero-cycle
// accept), read data returns one cycle after the grant, tagged with the port.
// Port 0 has fixed priority; port 1 wins once after STARVE_LIMIT lost cycles.
// Optional build macro DMEM_STATS_EN adds saturating grant/conflict counters.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int STAT_W       = 16
) (
  input  logic                clk,
  input  logic                sys_rst,
  dmem_port_arbiter_if.slave  bus
`ifdef DMEM_STATS_EN
  ,
  output logic [STAT_W-1:0]   stat_gnt0,
  output logic [STAT_W-1:0]   stat_gnt1,
  output logic [STAT_W-1:0]   stat_conf
`endif
);

  localparam int              CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || STAT_W < 1) begin : g_bad_param
    $error("dmem_port_arbiter: STARVE_LIMIT must be 1..15 and STAT_W >= 1");
  end

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_port_q, rd_port_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              gnt_any;
  logic              sel1;
  logic              we_sel;
  logic              rvalid_any;

  // Grant selection and memory strobes; everything is forced idle while in reset.
  always_comb begin
    gnt_any = 1'b0;
    sel1    = 1'b0;
    if (sys_rst) begin
      if (bus.req0 && bus.req1) begin
        gnt_any = 1'b1;
        sel1    = (starve_cnt_q == LIMIT);
      end else if (bus.req0) begin
        gnt_any = 1'b1;
      end else if (bus.req1) begin
        gnt_any = 1'b1;
        sel1    = 1'b1;
      end
    end
    we_sel        = sel1 ? bus.we1 : bus.we0;
    bus.gnt0      = gnt_any && !sel1;
    bus.gnt1      = gnt_any && sel1;
    bus.mem_en    = gnt_any;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt_any) begin
      bus.mem_we    = we_sel;
      bus.mem_addr  = sel1 ? bus.addr1  : bus.addr0;
      bus.mem_wdata = sel1 ? bus.wdata1 : bus.wdata0;
    end
  end

  // Read return: tagged rvalid with mem_rdata pass-through, otherwise hold last data.
  // Reset masks the return so an in-flight read is squashed in the reset cycle itself.
  always_comb begin
    rvalid_any  = sys_rst && rd_pend_q;
    bus.rvalid0 = rvalid_any && !rd_port_q;
    bus.rvalid1 = rvalid_any && rd_port_q;
    bus.rdata   = '0;
    if (sys_rst) begin
      bus.rdata = rvalid_any ? bus.mem_rdata : rdata_q;
    end
  end

  // Next-state: starvation counter, pending-read tag and held read data.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.req1 || (gnt_any && sel1)) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
    rd_pend_d = gnt_any && !we_sel;
    rd_port_d = sel1;
    rdata_d   = rvalid_any ? bus.mem_rdata : rdata_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_port_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_port_q    <= rd_port_d;
      rdata_q      <= rdata_d;
    end
  end

`ifdef DMEM_STATS_EN
  logic [STAT_W-1:0] stat_gnt0_q, stat_gnt0_d;
  logic [STAT_W-1:0] stat_gnt1_q, stat_gnt1_d;
  logic [STAT_W-1:0] stat_conf_q, stat_conf_d;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    sat_inc = (en && (v != '1)) ? v + STAT_W'(1) : v;
  endfunction

  // Saturating statistics next-state.
  always_comb begin
    stat_gnt0_d = sat_inc(stat_gnt0_q, gnt_any && !sel1);
    stat_gnt1_d = sat_inc(stat_gnt1_q, gnt_any && sel1);
    stat_conf_d = sat_inc(stat_conf_q, bus.req0 && bus.req1);
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      stat_gnt0_q <= '0;
      stat_gnt1_q <= '0;
      stat_conf_q <= '0;
    end else begin
      stat_gnt0_q <= stat_gnt0_d;
      stat_gnt1_q <= stat_gnt1_d;
      stat_conf_q <= stat_conf_d;
    end
  end

  assign stat_gnt0 = stat_gnt0_q;
  assign stat_gnt1 = stat_gnt1_q;
  assign stat_conf = stat_conf_q;
`endif

endmodule
